// File: rtl/chunked_addsub_pkg.sv
// chunked_addsub_pkg: shared ALU types and op-select constants
package chunked_addsub_pkg;
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;
endpackage

// File: rtl/chunked_addsub_slice.sv
// addsub_slice: combinational CHUNK-bit ripple of full adders
module addsub_slice #(
   parameter int CHUNK = 16
) (
   input  logic [CHUNK-1:0] x,
   input  logic [CHUNK-1:0] y,
   input  logic             cin,
   output logic [CHUNK-1:0] s,
   output logic             cout,
   output logic             c_msb_in
);
   logic [CHUNK:0] c;
   assign c[0] = cin;
   for (genvar i = 0; i < CHUNK; i++) begin : g_fa
      assign s[i]   = x[i] ^ y[i] ^ c[i];
      assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
   end
   assign cout     = c[CHUNK];
   assign c_msb_in = c[CHUNK-1];
endmodule

// File: rtl/chunked_addsub.sv
// chunked_addsub: multi-cycle add/sub, CHUNK bits per clock, with ZF/SF/OF/carry flags
module chunked_addsub
   import chunked_addsub_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int CHUNK = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             of,
   output logic             sf,
   output logic             zf
);
   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   state_t state, state_n;
   logic [WIDTH-1:0] a_q, b_q;
   logic [IW-1:0] idx;
   logic [BW-1:0] base;
   logic carry, last, accept, s_cout, s_cmsb;
   logic [CHUNK-1:0] s_sum;
   assign last        = idx == IW'(NCHUNK - 1);
   assign base        = BW'(idx * CHUNK);
   assign start_ready = !rst && (state == IDLE || (state == DONE && res_ready));
   assign accept      = start_valid && start_ready;
   assign res_valid   = state == DONE;
   assign sf          = sum[WIDTH-1];
   assign zf          = ~|sum;
   addsub_slice #(.CHUNK(CHUNK)) slice (
      .x(a_q[base +: CHUNK]),
      .y(b_q[base +: CHUNK]),
      .cin(carry),
      .s(s_sum),
      .cout(s_cout),
      .c_msb_in(s_cmsb)
   );
   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else state <= state_n;
   end
   // next state: a DONE handshake may chain straight into a new request
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    state_n = start_valid ? BUSY : IDLE;
         BUSY:    state_n = last ? DONE : BUSY;
         DONE:    state_n = res_ready ? (start_valid ? BUSY : IDLE) : DONE;
         default: state_n = IDLE;
      endcase
   end
   // operand capture, per-chunk ripple and final carry/overflow latch
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q   <= '0;
         b_q   <= '0;
         carry <= 1'b0;
         idx   <= '0;
         sum   <= '0;
         cout  <= 1'b0;
         of    <= 1'b0;
      end else if (accept) begin
         a_q   <= a;
         b_q   <= (sub == OP_ADD) ? b : ~b;
         carry <= sub == OP_SUB;
         idx   <= '0;
      end else if (state == BUSY) begin
         sum[base +: CHUNK] <= s_sum;
         carry <= s_cout;
         idx   <= last ? '0 : idx + 1'b1;
         if (last) begin
            cout <= s_cout;
            of   <= s_cmsb ^ s_cout;
         end
      end
   end
endmodule

// File: tb/tb_chunked_addsub.sv
// tb_chunked_addsub: scoreboard bench running CHUNK = 16, 64 and 1 side by side
module tb_chunked_addsub;
   typedef struct packed {
      logic [63:0] s;
      logic c, o, sg, z;
   } exp_t;
   logic clk = 0;
   int checks = 0;
   int errs = 0;
   always #5 clk = ~clk;

   function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", nm, act, req);
      end
   endfunction

   // reference: plain arithmetic, unsigned compare for borrow, sign rules for overflow
   function automatic exp_t model(input logic [63:0] x, input logic [63:0] y, input logic s);
      exp_t e;
      logic [64:0] w;
      w    = {1'b0, x} + {1'b0, y};
      e.s  = s ? x - y : x + y;
      e.c  = s ? (x >= y) : w[64];
      e.o  = s ? (x[63] != y[63] && e.s[63] != x[63]) : (x[63] == y[63] && e.s[63] != x[63]);
      e.sg = e.s[63];
      e.z  = e.s == 64'd0;
      return e;
   endfunction

   function automatic logic [63:0] pick();
      case ($urandom_range(0, 7))
         0: return 64'd0;
         1: return '1;
         2: return 64'h8000_0000_0000_0000;
         3: return 64'h7FFF_FFFF_FFFF_FFFF;
         default: return {$urandom, $urandom};
      endcase
   endfunction

   for (genvar g = 0; g < 3; g++) begin : lane
      localparam int CH = g == 0 ? 16 : g == 1 ? 64 : 1;
      localparam int N = 64 / CH;
      localparam int NRAND = g == 0 ? 3000 : g == 1 ? 10000 : 300;
      logic rst = 1, start_valid = 0, sub = 0, res_ready = 1, rr_rand = 0;
      logic [63:0] a = 0, b = 0;
      logic start_ready, res_valid, cout, of, sf, zf;
      logic [63:0] sum;
      bit lane_done = 0;
      exp_t q[$];

      chunked_addsub #(.WIDTH(64), .CHUNK(CH)) dut (
         .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
         .a(a), .b(b), .sub(sub), .res_valid(res_valid), .res_ready(res_ready),
         .sum(sum), .cout(cout), .of(of), .sf(sf), .zf(zf)
      );

      always @(negedge clk) begin
         if (!rst && res_valid && res_ready) begin
            if (q.size() == 0) begin
               checks++;
               errs++;
               $display("FAIL c%0d_spurious: result sum %0h with nothing outstanding", CH, sum);
            end else begin
               chk($sformatf("c%0d_result", CH), {sum, cout, of, sf, zf}, q.pop_front());
            end
         end
      end

      task automatic issue(input logic [63:0] x, input logic [63:0] y, input logic s, input bit push);
         int n = 0;
         @(negedge clk);
         a = x;
         b = y;
         sub = s;
         start_valid = 1;
         while (!start_ready && n < 1000) begin
            @(negedge clk);
            n++;
         end
         if (!start_ready) begin
            chk($sformatf("c%0d_accept_timeout", CH), 0, 1);
            start_valid = 0;
         end else begin
            if (push) q.push_back(model(x, y, s));
            @(posedge clk);
            #1;
            start_valid = 0;
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            sub = 1'($urandom);
         end
      endtask

      task automatic wait_result(input string nm);
         int lat = 0;
         @(negedge clk);
         while (!res_valid && lat < 200) begin
            lat++;
            @(negedge clk);
         end
         chk($sformatf("c%0d_%s_latency", CH, nm), lat, N);
      endtask

      initial begin : drv
         logic [67:0] snap;
         int n;
         repeat (2) @(negedge clk);
         chk($sformatf("c%0d_rst_hs", CH), {start_ready, res_valid}, 2'b00);
         chk($sformatf("c%0d_rst_regs", CH), {sum, cout, of, sf, zf}, {64'd0, 4'b0001});
         @(posedge clk);
         #1 rst = 0;
         @(negedge clk);
         chk($sformatf("c%0d_rel_ready", CH), start_ready, 1);

         issue(64'd5, 64'd7, 1'b1 ^ 1'b1, 1);
         wait_result("add");
         chk($sformatf("c%0d_add", CH), {sum, cout, of, sf, zf}, {64'd12, 4'b0000});
         issue(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 0, 1);
         wait_result("ovf");
         chk($sformatf("c%0d_ovf", CH), {sum, cout, of, sf, zf}, {64'h8000_0000_0000_0000, 4'b0110});
         issue(64'd3, 64'd3, 1, 1);
         wait_result("sub33");
         chk($sformatf("c%0d_sub33", CH), {sum, cout, of, sf, zf}, {64'd0, 4'b1001});
         issue(64'd0, 64'd1, 1, 1);
         wait_result("sub01");
         chk($sformatf("c%0d_sub01", CH), {sum, cout, of, sf, zf}, {64'hFFFF_FFFF_FFFF_FFFF, 4'b0010});
         issue(64'h8000_0000_0000_0000, 64'd1, 1, 1);
         wait_result("subovf");
         chk($sformatf("c%0d_subovf", CH), {sum, cout, of, sf, zf}, {64'h7FFF_FFFF_FFFF_FFFF, 4'b1100});

         @(posedge clk);
         #1 res_ready = 0;
         issue(64'h1234, 64'h0FF0, 0, 1);
         wait_result("bp");
         snap = {sum, cout, of, sf, zf};
         a = 64'd100;
         b = 64'd23;
         sub = 1;
         start_valid = 1;
         repeat (10) begin
            @(negedge clk);
            chk($sformatf("c%0d_bp_hold", CH), {res_valid, start_ready, sum, cout, of, sf, zf}, {2'b10, snap});
         end
         @(posedge clk);
         #1 res_ready = 1;
         q.push_back(model(64'd100, 64'd23, 1));
         @(negedge clk);
         chk($sformatf("c%0d_b2b_ready", CH), start_ready, 1);
         @(posedge clk);
         #1 start_valid = 0;
         wait_result("b2b");
         chk($sformatf("c%0d_b2b", CH), sum, 64'd77);

         issue(64'hDEAD, 64'hBEEF, 0, 0);
         if (N > 1) begin
            @(posedge clk);
            #1;
         end
         rst = 1;
         @(negedge clk);
         chk($sformatf("c%0d_rstb_ready", CH), start_ready, 0);
         @(posedge clk);
         #1;
         @(negedge clk);
         chk($sformatf("c%0d_rstb_hs", CH), {res_valid, start_ready}, 2'b00);
         chk($sformatf("c%0d_rstb_regs", CH), {sum, cout, of, sf, zf}, {64'd0, 4'b0001});
         @(posedge clk);
         #1 rst = 0;
         @(negedge clk);
         chk($sformatf("c%0d_rstb_rel", CH), start_ready, 1);
         issue(64'd1, 64'd1, 0, 1);
         wait_result("after_rst");
         chk($sformatf("c%0d_after_rst", CH), sum, 64'd2);

         rr_rand = 1;
         fork
            while (rr_rand) begin
               @(posedge clk);
               #1 res_ready = $urandom_range(0, 3) != 0;
            end
         join_none
         for (int i = 0; i < NRAND; i++) issue(pick(), pick(), 1'($urandom), 1);
         rr_rand = 0;
         @(posedge clk);
         #2 res_ready = 1;
         n = 0;
         while (q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
         end
         chk($sformatf("c%0d_drain", CH), q.size(), 0);
         lane_done = 1;
      end
   end

   initial begin
      int n = 0;
      while (!(lane[0].lane_done && lane[1].lane_done && lane[2].lane_done) && n < 95000) begin
         @(posedge clk);
         n++;
      end
      chk("all_lanes_done", {lane[0].lane_done, lane[1].lane_done, lane[2].lane_done}, 3'b111);
      $display("== %0d vectors applied, %0d miscompares ==", checks, errs);
      $finish;
   end
endmodule
